// File: rtl/mtm_alu_pkg.sv
// Shared constants and CRC helper for the mtm_Alu serial datapath.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  typedef enum logic [2:0] {
    RX_IDLE, RX_CMD, RX_DATA, RX_STOP, RX_RESYNC
  } rx_state_t;

  // Bit-serial x^4+x+1 LFSR, data[67] is the first bit on the wire.
  function automatic logic [3:0] crc4_d68(input logic [67:0] data, input logic [3:0] crc);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_rx_packet.sv
// Packet receiver: frames one 11-bit start/cmd/payload/stop packet from sin.
module mtm_alu_rx_packet
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       pkt_valid,
  output logic       pkt_cmd,
  output logic [7:0] pkt_byte,
  output logic       pkt_frame_err
);

  rx_state_t  state, state_n;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       cmd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      cmd_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RX_CMD) cmd_q <= sin;
      if (state == RX_DATA) begin
        shreg   <= {shreg[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Strobes are combinational on the stop-bit cycle so the top can register
  // its result at the same edge that samples the stop bit.
  always_comb begin
    state_n       = state;
    pkt_valid     = 1'b0;
    pkt_frame_err = 1'b0;
    case (state)
      RX_IDLE:   if (!sin) state_n = RX_CMD;
      RX_CMD:    state_n = RX_DATA;
      RX_DATA:   if (bit_cnt == 3'd7) state_n = RX_STOP;
      RX_STOP: begin
        pkt_valid     = sin;
        pkt_frame_err = !sin;
        state_n       = sin ? RX_IDLE : RX_RESYNC;
      end
      RX_RESYNC: if (sin) state_n = RX_IDLE;
      default:   state_n = RX_IDLE;
    endcase
  end

  assign pkt_cmd  = cmd_q;
  assign pkt_byte = shreg;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Frame assembly and checking: 8 DATA packets + 1 CTL packet -> A/B/op or error.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter logic [3:0] CRC_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  logic       pkt_valid, pkt_cmd, pkt_frame_err;
  logic [7:0] pkt_byte;

  mtm_alu_rx_packet u_rx (
    .clk           (clk),
    .rst           (rst),
    .sin           (sin),
    .pkt_valid     (pkt_valid),
    .pkt_cmd       (pkt_cmd),
    .pkt_byte      (pkt_byte),
    .pkt_frame_err (pkt_frame_err)
  );

  logic [7:0][7:0] data_q;
  logic [3:0]      cnt;
  logic            frame_err;
  logic [31:0]     fr_a, fr_b;
  logic [2:0]      ctl_op;
  logic [2:0]      ctl_err;

  assign fr_b   = {data_q[0], data_q[1], data_q[2], data_q[3]};
  assign fr_a   = {data_q[4], data_q[5], data_q[6], data_q[7]};
  assign ctl_op = pkt_byte[6:4];

  always_comb begin
    ctl_err = '0;
    if (cnt != 4'd8 || frame_err || pkt_byte[7])
      ctl_err[ERR_DATA] = 1'b1;
    else if (crc4_d68({fr_b, fr_a, 1'b1, ctl_op}, CRC_INIT) != pkt_byte[3:0])
      ctl_err[ERR_CRC] = 1'b1;
    else if (!op_valid(ctl_op))
      ctl_err[ERR_OP] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      op        <= '0;
      err_flags <= '0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      if (pkt_frame_err) frame_err <= 1'b1;
      if (pkt_valid && pkt_cmd == PKT_DATA) begin
        if (cnt < 4'd8) data_q[cnt[2:0]] <= pkt_byte;
        // 9 marks "too many DATA packets" and must not wrap back to 8
        if (cnt != 4'd9) cnt <= cnt + 4'd1;
      end
      if (pkt_valid && pkt_cmd == PKT_CTL) begin
        cnt       <= '0;
        frame_err <= 1'b0;
        if (ctl_err != '0) begin
          err_valid <= 1'b1;
          err_flags <= ctl_err;
        end else begin
          out_valid <= 1'b1;
          A         <= fr_a;
          B         <= fr_b;
          op        <= ctl_op;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench with a packet-level reference model and a per-cycle comparator.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b1;
  logic        out_valid, err_valid;
  logic [31:0] A, B;
  logic [2:0]  op, err_flags;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_ov = 0, n_ev = 0;
  bit chk_en = 1'b0;

  // model state
  logic        exp_ov = 1'b0, exp_ev = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [2:0]  exp_op = '0, exp_ef = '0;
  logic [7:0]  mbytes [8];
  int          nd = 0;
  bit          ferr = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // CRC as polynomial long division of data*x^4 by x^4+x+1 (seed 0).
  function automatic logic [3:0] model_crc(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid === 1'b1) n_ov++;
      if (err_valid === 1'b1) n_ev++;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("err_valid", {31'd0, err_valid}, {31'd0, exp_ev});
      chk("A", A, exp_a);
      chk("B", B, exp_b);
      chk("op", {29'd0, op}, {29'd0, exp_op});
      chk("err_flags", {29'd0, err_flags}, {29'd0, exp_ef});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
    exp_ov = 1'b0;
    exp_ev = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic model_ctl(input logic [7:0] pl);
    logic [31:0] b, a;
    logic [2:0]  o;
    b = {mbytes[0], mbytes[1], mbytes[2], mbytes[3]};
    a = {mbytes[4], mbytes[5], mbytes[6], mbytes[7]};
    o = pl[6:4];
    if (nd != 8 || ferr || pl[7]) begin exp_ev = 1'b1; exp_ef = 3'b100; end
    else if (model_crc({b, a, 1'b1, o}) != pl[3:0]) begin exp_ev = 1'b1; exp_ef = 3'b010; end
    else if (!(o == 3'd0 || o == 3'd1 || o == 3'd4 || o == 3'd5)) begin exp_ev = 1'b1; exp_ef = 3'b001; end
    else begin exp_ov = 1'b1; exp_a = a; exp_b = b; exp_op = o; end
    nd = 0;
    ferr = 1'b0;
  endtask

  task automatic send_pkt(input logic cmd, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(cmd);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
    if (!stop) ferr = 1'b1;
    else if (!cmd) begin
      if (nd < 8) mbytes[nd] = pl;
      nd++;
    end else model_ctl(pl);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                            input logic [3:0] crc_x, input logic ctl7, input int bad);
    logic [63:0] d;
    d = {b, a};
    for (int i = 0; i < 8; i++) send_pkt(1'b0, d[63 - 8*i -: 8], i != bad);
    send_pkt(1'b1, {ctl7, o, model_crc({b, a, 1'b1, o}) ^ crc_x}, bad != 8);
  endtask

  task automatic pulse_rst();
    sin = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0; ferr = 1'b0;
    exp_ov = 1'b0; exp_ev = 1'b0;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_ef = '0;
  endtask

  int ov0, ev0;
  logic [31:0] pat;
  logic [2:0]  ops [4];

  initial begin
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_op", {29'd0, op}, 32'd0);
    chk("rst_err_flags", {29'd0, err_flags}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("crc_pin_zero", {28'd0, model_crc(68'd0)}, 32'h0);
    chk("crc_pin_one", {28'd0, model_crc(68'd1)}, 32'h3);
    chk("crc_pin_frame1", {28'd0, model_crc({32'd2, 32'd4, 1'b1, 3'b100})}, 32'hE);
    idle(3);

    // basic accepted frame
    ov0 = n_ov; ev0 = n_ev;
    send_frame(32'd2, 32'd4, 3'b100, 4'h0, 1'b0, -1);
    idle(2);
    chk("f1_A", A, 32'd4);
    chk("f1_B", B, 32'd2);
    chk("f1_op", {29'd0, op}, 32'h4);
    chk("f1_ov_cnt", n_ov - ov0, 1);
    chk("f1_ev_cnt", n_ev - ev0, 0);

    // CRC bit 0 flipped
    ov0 = n_ov; ev0 = n_ev;
    send_frame(32'd2, 32'd4, 3'b100, 4'h1, 1'b0, -1);
    idle(2);
    chk("crc_err_flags", {29'd0, err_flags}, 32'h2);
    chk("crc_ov_cnt", n_ov - ov0, 0);
    chk("crc_ev_cnt", n_ev - ev0, 1);

    // too few, then too many DATA packets, then recovery
    send_pkt(1'b0, 8'h55, 1'b1);
    send_pkt(1'b0, 8'h0F, 1'b1);
    send_pkt(1'b1, 8'h50, 1'b1);
    idle(2);
    chk("short_err_flags", {29'd0, err_flags}, 32'h4);
    for (int i = 0; i < 10; i++) send_pkt(1'b0, 8'(i * 17), 1'b1);
    send_pkt(1'b1, 8'h50, 1'b1);
    idle(2);
    chk("long_err_flags", {29'd0, err_flags}, 32'h4);
    ov0 = n_ov;
    send_frame(32'h12345678, 32'h9ABCDEF0, 3'b001, 4'h0, 1'b0, -1);
    idle(2);
    chk("recover_ov_cnt", n_ov - ov0, 1);

    // invalid opcodes with good CRC
    for (int i = 0; i < 4; i++) begin
      send_frame(32'hA5A5_0001, 32'h0F0F_0002, (i == 0) ? 3'b010 : (i == 1) ? 3'b011 :
                 (i == 2) ? 3'b110 : 3'b111, 4'h0, 1'b0, -1);
      idle(2);
      chk("badop_err_flags", {29'd0, err_flags}, 32'h1);
    end

    // CTL payload bit 7 set
    send_frame(32'd1, 32'd1, 3'b000, 4'h0, 1'b1, -1);
    idle(2);
    chk("ctl7_err_flags", {29'd0, err_flags}, 32'h4);

    // extremes under all opcodes, back-to-back
    ov0 = n_ov; ev0 = n_ev;
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? 32'hFFFF_FFFF : 32'h0;
      for (int i = 0; i < 4; i++) send_frame(pat, pat, ops[i], 4'h0, 1'b0, -1);
    end
    idle(2);
    chk("b2b_ov_cnt", n_ov - ov0, 8);
    chk("b2b_ev_cnt", n_ev - ev0, 0);

    // reset during the 5th DATA packet
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hC3, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ov0 = n_ov; ev0 = n_ev;
    pulse_rst();
    idle(2);
    send_frame(32'd3, 32'd7, 3'b101, 4'h0, 1'b0, -1);
    idle(2);
    chk("abort_A", A, 32'd7);
    chk("abort_B", B, 32'd3);
    chk("abort_op", {29'd0, op}, 32'h5);
    chk("abort_ov_cnt", n_ov - ov0, 1);
    chk("abort_ev_cnt", n_ev - ev0, 0);

    // framing error on packet 3, then a clean frame
    ov0 = n_ov; ev0 = n_ev;
    send_frame(32'd3, 32'd7, 3'b101, 4'h0, 1'b0, 2);
    idle(2);
    chk("ferr_err_flags", {29'd0, err_flags}, 32'h4);
    chk("ferr_ev_cnt", n_ev - ev0, 1);
    send_frame(32'd3, 32'd7, 3'b101, 4'h0, 1'b0, -1);
    idle(2);
    chk("ferr_ov_cnt", n_ov - ov0, 1);
    chk("ferr_A", A, 32'd7);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
